// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and pixel widths for the frame scheduler slice.
package vga_pkg;

   // 640x480@60 default raster timing
   localparam int H_ACTIVE_D = 640;
   localparam int H_FP_D     = 16;
   localparam int H_SYNC_D   = 96;
   localparam int H_BP_D     = 48;
   localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
   localparam int H_SYNC_START_D = H_ACTIVE_D + H_FP_D;
   localparam int H_SYNC_END_D   = H_ACTIVE_D + H_FP_D + H_SYNC_D;

   localparam int V_ACTIVE_D = 480;
   localparam int V_FP_D     = 10;
   localparam int V_SYNC_D   = 2;
   localparam int V_BP_D     = 33;
   localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;
   localparam int V_SYNC_START_D = V_ACTIVE_D + V_FP_D;
   localparam int V_SYNC_END_D   = V_ACTIVE_D + V_FP_D + V_SYNC_D;

   localparam int CW_D    = 10;
   localparam int N_SRC_D = 4;

   // One colour nibble, and a packed {R,G,B} pixel
   localparam int RGB_W = 4;
   localparam int PIX_W = 3 * RGB_W;

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters, active-region flag, frame start and pre-register syncs.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FP     = H_FP_D,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FP     = V_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D,
   parameter int CW       = CW_D
) (
   input  logic          clk,
   input  logic          rst,
   output logic [CW-1:0] h_cnt,
   output logic [CW-1:0] v_cnt,
   output logic          pix_valid,
   output logic          frame_start,
   output logic          h_sync_pre,
   output logic          v_sync_pre,
   output logic          arb_point
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] V_ACT_L  = CW'(V_ACTIVE - 1);
   localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

   // Horizontal counter wraps every line; vertical advances on each wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   assign pix_valid   = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
   assign frame_start = (h_cnt == '0) && (v_cnt == '0);
   // Syncs are active low inside their pulse window
   assign h_sync_pre  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
   assign v_sync_pre  = !((v_cnt >= VS_START) && (v_cnt < VS_END));
   // Last pixel clock of the last visible line: grant changes on the next edge
   assign arb_point   = (h_cnt == H_LAST) && (v_cnt == V_ACT_L);

endmodule

// File: rtl/vga_frame_scheduler.sv
// Shares one VGA output between N_SRC pixel sources, one owner per frame,
// chosen round-robin at the start of vertical blanking so frames never tear.
// Sources hold req high as a level for as long as they want the display;
// there is no per-pixel handshake, the owner simply supplies rgb_in one
// cycle after seeing pix_x/pix_y.
module vga_frame_scheduler
   import vga_pkg::*;
#(
   parameter int N_SRC    = N_SRC_D,
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FP     = H_FP_D,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FP     = V_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D,
   parameter int CW       = CW_D
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_SRC-1:0]       req,
   input  logic [PIX_W*N_SRC-1:0] rgb_in,
   output logic [N_SRC-1:0]       gnt,
   output logic [CW-1:0]          pix_x,
   output logic [CW-1:0]          pix_y,
   output logic                   pix_valid,
   output logic                   frame_start,
   output logic                   h_sync,
   output logic                   v_sync,
   output logic [RGB_W-1:0]       R,
   output logic [RGB_W-1:0]       G,
   output logic [RGB_W-1:0]       B
);

   localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   logic             h_sync_pre;
   logic             v_sync_pre;
   logic             arb_point;
   logic [IW-1:0]    last;
   logic             valid_d;
   logic             win_found;
   logic [IW-1:0]    win_idx;
   logic [N_SRC-1:0] win_onehot;
   logic [PIX_W-1:0] rgb_sel;
   logic             req_owner;
   logic             visible;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .CW       (CW)
   ) u_timing (
      .clk         (clk),
      .rst         (rst),
      .h_cnt       (pix_x),
      .v_cnt       (pix_y),
      .pix_valid   (pix_valid),
      .frame_start (frame_start),
      .h_sync_pre  (h_sync_pre),
      .v_sync_pre  (v_sync_pre),
      .arb_point   (arb_point)
   );

   // Round-robin search: first requester after the previous winner, wrapping
   always_comb begin
      int idx;
      idx        = 0;
      win_found  = 1'b0;
      win_idx    = last;
      win_onehot = '0;
      for (int k = 1; k <= N_SRC; k++) begin
         idx = (int'(last) + k) % N_SRC;
         if (!win_found && req[idx]) begin
            win_found       = 1'b1;
            win_idx         = IW'(idx);
            win_onehot[idx] = 1'b1;
         end
      end
   end

   // Grant is only re-decided at the arbitration point and held all frame.
   // While a grant is live, last always names the owner.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt  <= '0;
         last <= IW'(N_SRC - 1);
      end else if (arb_point) begin
         gnt <= win_onehot;
         if (win_found) begin
            last <= win_idx;
         end
      end
   end

   // Select the owner's pixel and request bit using last as the index
   always_comb begin
      rgb_sel   = '0;
      req_owner = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         if (IW'(i) == last) begin
            rgb_sel   = rgb_in[i*PIX_W +: PIX_W];
            req_owner = req[i];
         end
      end
   end

   // Black unless the delayed active flag is set and the owner still requests
   assign visible = valid_d && (|gnt) && req_owner;

   // Output register stage for sync and colour; reset forces syncs inactive
   always_ff @(posedge clk) begin
      if (rst) begin
         h_sync  <= 1'b1;
         v_sync  <= 1'b1;
         valid_d <= 1'b0;
         R       <= '0;
         G       <= '0;
         B       <= '0;
      end else begin
         h_sync  <= h_sync_pre;
         v_sync  <= v_sync_pre;
         valid_d <= pix_valid;
         if (visible) begin
            {R, G, B} <= rgb_sel;
         end else begin
            {R, G, B} <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Directed bench: one default-timing instance for the 640x480 sync checks,
// one reduced-timing instance for arbitration, colour and reset checks.
module tb_vga_frame_scheduler;

   logic clk;
   logic rst_b;
   logic rst_s;
   logic [3:0]  req_b;
   logic [3:0]  req_s;
   logic [47:0] rgb_b;
   logic [47:0] rgb_s;

   logic [3:0] gnt_b, gnt_s;
   logic [9:0] pix_x_b, pix_y_b, pix_x_s, pix_y_s;
   logic       pix_valid_b, pix_valid_s;
   logic       frame_start_b, frame_start_s;
   logic       h_sync_b, v_sync_b, h_sync_s, v_sync_s;
   logic [3:0] r_b, g_b, b_b, r_s, g_s, b_s;

   int n_checks;
   int n_errors;

   vga_frame_scheduler u_big (
      .clk         (clk),
      .rst         (rst_b),
      .req         (req_b),
      .rgb_in      (rgb_b),
      .gnt         (gnt_b),
      .pix_x       (pix_x_b),
      .pix_y       (pix_y_b),
      .pix_valid   (pix_valid_b),
      .frame_start (frame_start_b),
      .h_sync      (h_sync_b),
      .v_sync      (v_sync_b),
      .R           (r_b),
      .G           (g_b),
      .B           (b_b)
   );

   vga_frame_scheduler #(
      .N_SRC    (4),
      .H_ACTIVE (8),
      .H_FP     (2),
      .H_SYNC   (2),
      .H_BP     (2),
      .V_ACTIVE (4),
      .V_FP     (1),
      .V_SYNC   (1),
      .V_BP     (1),
      .CW       (10)
   ) u_small (
      .clk         (clk),
      .rst         (rst_s),
      .req         (req_s),
      .rgb_in      (rgb_s),
      .gnt         (gnt_s),
      .pix_x       (pix_x_s),
      .pix_y       (pix_y_s),
      .pix_valid   (pix_valid_s),
      .frame_start (frame_start_s),
      .h_sync      (h_sync_s),
      .v_sync      (v_sync_s),
      .R           (r_s),
      .G           (g_s),
      .B           (b_s)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset the small instance; on return the reset state is visible (k = 0)
   task automatic reset_small(input logic [3:0] r);
      rst_s = 1'b1;
      req_s = r;
      tick();
      rst_s = 1'b0;
   endtask

   function automatic logic [11:0] col_s();
      return {r_s, g_s, b_s};
   endfunction

   initial begin
      int cnt;
      int lows;
      int run;
      bit first_run;
      int rgb_nz;
      int vs_lows;
      int fs_cnt, fs_second, hs_low, vs_low, pv_cnt, first_hfall, first_vfall;
      int n_chg, bad_chg;
      logic [3:0] prev_gnt;
      logic [11:0] col_tab [6];
      logic [3:0]  gnt_tab [6];
      logic [3:0]  rr_tab [7];

      col_tab = '{12'h000, 12'h111, 12'h222, 12'h333, 12'h444, 12'h111};
      gnt_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rr_tab  = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0010, 4'b0100};

      n_checks = 0;
      n_errors = 0;
      rst_b = 1'b1;
      rst_s = 1'b1;
      req_b = 4'b0000;
      req_s = 4'b0000;
      rgb_b = {12'h444, 12'h333, 12'h222, 12'h111};
      rgb_s = {12'h444, 12'h333, 12'h222, 12'h111};
      repeat (3) tick();

      // Reset state of both instances
      check("rst_gnt_s",    gnt_s, 4'b0000);
      check("rst_x_s",      pix_x_s, 0);
      check("rst_y_s",      pix_y_s, 0);
      check("rst_hs_s",     h_sync_s, 1);
      check("rst_vs_s",     v_sync_s, 1);
      check("rst_rgb_s",    col_s(), 12'h000);
      check("rst_fs_s",     frame_start_s, 1);
      check("rst_pv_s",     pix_valid_s, 1);
      check("rst_gnt_b",    gnt_b, 4'b0000);
      check("rst_xy_b",     {pix_x_b, pix_y_b}, 0);
      check("rst_fs_pv_b",  {frame_start_b, pix_valid_b}, 2'b11);
      check("rst_sync_b",   {h_sync_b, v_sync_b}, 2'b11);

      // Default timing, no requests: first h_sync fall and sync widths
      rst_b = 1'b0;
      cnt = 0;
      for (int i = 0; i < 2000; i++) begin
         tick();
         cnt++;
         if (!h_sync_b) break;
      end
      check("big_first_hfall", cnt, 657);
      lows = 0;
      run = 0;
      first_run = 1'b1;
      rgb_nz = 0;
      vs_lows = 0;
      for (int i = 0; i < 1600; i++) begin
         if (!h_sync_b) lows++;
         if (first_run && !h_sync_b) run++;
         else first_run = 1'b0;
         if ({r_b, g_b, b_b} != 12'h000) rgb_nz++;
         if (!v_sync_b) vs_lows++;
         tick();
      end
      check("big_hs_low_2lines", lows, 192);
      check("big_hs_pulse_len", run, 96);
      check("big_rgb_black", rgb_nz, 0);
      check("big_vs_idle", vs_lows, 0);
      rst_b = 1'b1;

      // Reduced timing, no requests: periods and pulse counts over 2 frames
      reset_small(4'b0000);
      fs_cnt = 0; fs_second = -1; hs_low = 0; vs_low = 0; pv_cnt = 0;
      first_hfall = -1; first_vfall = -1; rgb_nz = 0;
      for (int k = 0; k < 196; k++) begin
         if (frame_start_s) begin
            fs_cnt++;
            if (k > 0 && fs_second < 0) fs_second = k;
         end
         if (!h_sync_s) begin
            hs_low++;
            if (first_hfall < 0) first_hfall = k;
         end
         if (!v_sync_s) begin
            vs_low++;
            if (first_vfall < 0) first_vfall = k;
         end
         if (pix_valid_s) pv_cnt++;
         if (col_s() != 12'h000) rgb_nz++;
         tick();
      end
      check("s_fs_count", fs_cnt, 2);
      check("s_fs_period", fs_second, 98);
      check("s_hs_low", hs_low, 28);
      check("s_vs_low", vs_low, 28);
      check("s_pv_count", pv_cnt, 64);
      check("s_first_hfall", first_hfall, 11);
      check("s_first_vfall", first_vfall, 71);
      check("s_rgb_black", rgb_nz, 0);

      // All four request: frames show 000,111,222,333,444,111
      reset_small(4'b1111);
      n_chg = 0; bad_chg = 0; prev_gnt = 4'b0000;
      for (int k = 0; k < 588; k++) begin
         if (gnt_s != prev_gnt) begin
            n_chg++;
            if (k % 98 != 56) bad_chg++;
         end
         prev_gnt = gnt_s;
         if (k == 55) check("rr_gnt_before_arb", gnt_s, 4'b0000);
         if (k == 56) check("rr_gnt_after_arb", gnt_s, 4'b0001);
         if (k == 99) check("rr_col_latency0", col_s(), 12'h000);
         if (k == 100) check("rr_col_latency1", col_s(), 12'h111);
         if (k % 98 == 20) begin
            check($sformatf("rr_col_f%0d", k / 98), col_s(), col_tab[k / 98]);
            check($sformatf("rr_gnt_f%0d", k / 98), gnt_s, gnt_tab[k / 98]);
         end
         tick();
      end
      check("rr_gnt_changes", n_chg, 6);
      check("rr_gnt_change_pos", bad_chg, 0);

      // Sparse requests 0101, then req[1] rises while source 2 owns
      reset_small(4'b0101);
      for (int k = 0; k < 650; k++) begin
         if (k % 98 == 60) check($sformatf("sp_gnt_f%0d", k / 98), gnt_s, rr_tab[k / 98]);
         if (k == 420) check("sp_midframe_hold", gnt_s, 4'b0100);
         if (k == 400) req_s = 4'b0111;
         tick();
      end

      // Owner drops req at pixel (3,1) of frame 1, then reset mid-line
      reset_small(4'b1111);
      for (int k = 0; k <= 230; k++) begin
         if (k == 115) begin
            check("drop_col_before", col_s(), 12'h111);
            req_s = 4'b1110;
         end
         if (k == 116) begin
            check("drop_col_black", col_s(), 12'h000);
            check("drop_gnt_hold", gnt_s, 4'b0001);
         end
         if (k == 150) check("drop_gnt_hold_late", gnt_s, 4'b0001);
         if (k == 160) check("drop_next_owner", gnt_s, 4'b0010);
         if (k == 216) check("drop_next_col", col_s(), 12'h222);
         if (k == 230) begin
            check("pre_rst_active", pix_valid_s, 1);
            rst_s = 1'b1;
         end
         tick();
      end
      check("mid_rst_sync", {h_sync_s, v_sync_s}, 2'b11);
      check("mid_rst_rgb", col_s(), 12'h000);
      check("mid_rst_gnt", gnt_s, 4'b0000);
      check("mid_rst_xy", {pix_x_s, pix_y_s}, 0);
      rst_s = 1'b0;
      req_s = 4'b1111;
      for (int k = 0; k < 60; k++) begin
         if (k == 55) check("rst_rearb_before", gnt_s, 4'b0000);
         if (k == 56) check("rst_rearb_src0", gnt_s, 4'b0001);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
